// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out frame receiver with a start/stop framing check and Valid/Ack handshake.
// Optional even-parity bit is enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer #(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         W,
  input  logic         En,
  input  logic         Ack,
  output logic [N-1:0] Q,
  output logic         Valid,
  output logic         FrameError,
  output logic         Overrun,
  output logic         ParityError
);

  localparam int CW = $clog2(N + 1);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  bit_cnt;
  logic [N-1:0]   shift_reg;
  logic           last_bit;
  logic           frame_good;
  logic           load;

  assign last_bit   = (bit_cnt == CW'(N - 1));
  assign frame_good = En && (state == STOP) && W;
  assign load       = frame_good && (!Valid || Ack);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (En) begin
      case (state)
        IDLE:      if (!W) next_state = DATA;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        DATA:      if (last_bit) next_state = PARITY;
        PARITY:    next_state = STOP;
`else
        DATA:      if (last_bit) next_state = STOP;
`endif
        STOP:      next_state = W ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (W) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Consuming a word and loading a new one can share an edge; the load wins for Valid.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      Q          <= '0;
      Valid      <= 1'b0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      if (En && (state == IDLE) && !W) bit_cnt <= '0;
      if (En && (state == DATA)) begin
        shift_reg <= {W, shift_reg[N-1:1]};
        bit_cnt   <= bit_cnt + CW'(1);
      end
      if (Valid && Ack) begin
        Valid   <= 1'b0;
        Overrun <= 1'b0;
      end
      if (load) begin
        Q          <= shift_reg;
        Valid      <= 1'b1;
        FrameError <= 1'b0;
      end else if (frame_good) begin
        Overrun <= 1'b1;
      end
      if (En && (state == STOP) && !W) FrameError <= 1'b1;
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic parity_bit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      parity_bit  <= 1'b0;
      ParityError <= 1'b0;
    end else begin
      if (En && (state == PARITY)) parity_bit <= W;
      if (load) ParityError <= (^shift_reg) ^ parity_bit;
    end
  end
`else
  assign ParityError = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed table, hand-written corner cases,
// and randomized traffic against a queue-based frame model.
module tb_serial_deserializer;

  localparam int N = 4;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         W = 1'b1;
  logic         En = 1'b0;
  logic         Ack = 1'b0;
  logic [N-1:0] Q;
  logic         Valid;
  logic         FrameError;
  logic         Overrun;
  logic         ParityError;

  serial_deserializer #(.N(N)) dut (
    .Clock(Clock), .Reset(Reset), .W(W), .En(En), .Ack(Ack),
    .Q(Q), .Valid(Valid), .FrameError(FrameError), .Overrun(Overrun),
    .ParityError(ParityError)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: collects the samples of a frame in a queue and judges it when complete.
  logic [N-1:0] m_q;
  bit           m_valid, m_fe, m_ovr, m_pe;
  int           m_mode;
  bit           frame_bits[$];

  typedef struct {
    logic [N-1:0] data;
    bit           stop;
    bit           ack;
    logic [N-1:0] exp_q;
    bit           exp_valid;
    bit           exp_fe;
    bit           exp_ovr;
  } vec_t;

  vec_t tbl[5];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge(bit rst, bit w, bit en, bit ack);
    bit           old_valid;
    logic [N-1:0] data;
    bit           par;
    if (rst) begin
      m_q = '0; m_valid = 0; m_fe = 0; m_ovr = 0; m_pe = 0; m_mode = 0;
      frame_bits.delete();
      return;
    end
    old_valid = m_valid;
    if (old_valid && ack) begin
      m_valid = 0;
      m_ovr   = 0;
    end
    if (!en) return;
    case (m_mode)
      0: if (!w) begin
        m_mode = 1;
        frame_bits.delete();
      end
      1: begin
        frame_bits.push_back(w);
        if (frame_bits.size() == N + PB + 1) begin
          data = '0;
          par  = 0;
          for (int i = 0; i < N; i++) data[i] = frame_bits[i];
          for (int i = 0; i < N + PB; i++) par ^= frame_bits[i];
          if (w) begin
            if (!old_valid || ack) begin
              m_q = data; m_valid = 1; m_fe = 0;
              m_pe = (PB == 1) ? par : 1'b0;
            end else begin
              m_ovr = 1;
            end
            m_mode = 0;
          end else begin
            m_fe   = 1;
            m_mode = 2;
          end
        end
      end
      default: if (w) m_mode = 0;
    endcase
  endtask

  task automatic checkOutput();
    check("q", 32'(Q), 32'(m_q));
    check("valid", 32'(Valid), 32'(m_valid));
    check("frame_error", 32'(FrameError), 32'(m_fe));
    check("overrun", 32'(Overrun), 32'(m_ovr));
    check("parity_error", 32'(ParityError), 32'(m_pe));
  endtask

  task automatic applyStimulus(bit rst, bit w, bit en, bit ack);
    Reset = rst; W = w; En = en; Ack = ack;
    @(posedge Clock);
    modelEdge(rst, w, en, ack);
    #1;
    checkOutput();
  endtask

  // Sends start, data LSB-first, optional parity, stop; gap inserts En=0 cycles with junk on W.
  task automatic sendFrame(logic [N-1:0] data, bit stop, bit ack_at_stop, int gap, bit bad_par);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < N; i++) bits.push_back(data[i]);
    if (PB == 1) bits.push_back((^data) ^ bad_par);
    bits.push_back(stop);
    for (int i = 0; i < bits.size(); i++) begin
      applyStimulus(0, bits[i], 1, (i == bits.size() - 1) && ack_at_stop);
      for (int g = 0; g < gap; g++) applyStimulus(0, 1'($urandom), 0, 0);
    end
  endtask

  task automatic expectOut(string tag, logic [N-1:0] q, bit v, bit fe, bit ov);
    check({tag, "_q"}, 32'(Q), 32'(q));
    check({tag, "_valid"}, 32'(Valid), 32'(v));
    check({tag, "_fe"}, 32'(FrameError), 32'(fe));
    check({tag, "_ovr"}, 32'(Overrun), 32'(ov));
  endtask

  initial begin
    tbl[0] = '{4'b1101, 1, 0, 4'b1101, 1, 0, 0};
    tbl[1] = '{4'b0011, 1, 0, 4'b1101, 1, 0, 1};
    tbl[2] = '{4'b0110, 1, 1, 4'b0110, 1, 0, 0};
    tbl[3] = '{4'b1001, 0, 0, 4'b0110, 1, 1, 0};
    tbl[4] = '{4'b0101, 1, 1, 4'b0101, 1, 0, 0};

    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    expectOut("reset", '0, 0, 0, 0);
    check("reset_pe", 32'(ParityError), 32'(0));
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
    check("idle_valid", 32'(Valid), 32'(0));

    sendFrame(4'b1101, 1, 0, 0, 0);
    expectOut("frame", 4'b1101, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    expectOut("hold", 4'b1101, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    check("ack_valid", 32'(Valid), 32'(0));

    sendFrame(4'b1101, 1, 0, 1, 0);
    expectOut("sparse_en", 4'b1101, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);

    sendFrame(4'b1001, 0, 0, 0, 0);
    expectOut("bad_stop", 4'b1101, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    sendFrame(4'b0110, 1, 0, 0, 0);
    expectOut("recover", 4'b0110, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);

    sendFrame(4'b1101, 1, 0, 0, 0);
    sendFrame(4'b0011, 1, 0, 0, 0);
    expectOut("overrun", 4'b1101, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    expectOut("overrun_ack", 4'b1101, 0, 0, 0);
    sendFrame(4'b0011, 1, 0, 0, 0);
    sendFrame(4'b0101, 1, 1, 0, 0);
    expectOut("ack_on_load", 4'b0101, 1, 0, 0);

    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    sendFrame(4'b1001, 1, 0, 0, 0);
    expectOut("mid_reset", 4'b1001, 1, 0, 0);
    check("mid_reset_pe", 32'(ParityError), 32'(0));

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    applyStimulus(0, 1, 0, 1);
    sendFrame(4'b1101, 1, 0, 0, 0);
    check("parity_ok_q", 32'(Q), 32'(4'b1101));
    check("parity_ok_pe", 32'(ParityError), 32'(0));
    applyStimulus(0, 1, 0, 1);
    sendFrame(4'b1101, 1, 0, 0, 1);
    check("parity_bad_q", 32'(Q), 32'(4'b1101));
    check("parity_bad_pe", 32'(ParityError), 32'(1));
`endif

    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 0);
      sendFrame(tbl[i].data, tbl[i].stop, tbl[i].ack, 0, 0);
      expectOut($sformatf("tbl%0d", i), tbl[i].exp_q, tbl[i].exp_valid,
                tbl[i].exp_fe, tbl[i].exp_ovr);
    end

    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
